// File: rtl/id_ex_stage.sv
// ID/EX pipeline stage: elastic two-entry (main + skid) register carrying
// decoded operands and control bits from decode to execute, with flush and
// zeroed control bits whenever the execute side sees a bubble.
module id_ex_stage #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned REG_W   = 8,
  parameter int unsigned ALUFN_W = 1
) (
  input  logic               clk2,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_imm,
  input  logic [DATA_W-1:0]  in_a,
  input  logic [DATA_W-1:0]  in_b,
  input  logic [REG_W-1:0]   in_m1,
  input  logic [REG_W-1:0]   in_m2,
  input  logic               in_alu_src,
  input  logic               in_mem_write,
  input  logic               in_mem_read,
  input  logic               in_mem_to_reg,
  input  logic [ALUFN_W-1:0] in_alu_fn,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_imm,
  output logic [DATA_W-1:0]  out_a,
  output logic [DATA_W-1:0]  out_b,
  output logic [REG_W-1:0]   out_m1,
  output logic [REG_W-1:0]   out_m2,
  output logic               out_alu_src,
  output logic [ALUFN_W-1:0] out_alu_fn,
  output logic               out_mem_write,
  output logic               out_mem_read,
  output logic               out_mem_to_reg,
  output logic [1:0]         occ
);

  // Control bits sit in the low CTRL_W bits so bubbles can clear them as a slice.
  localparam int unsigned CTRL_W = ALUFN_W + 4;
  localparam int unsigned PL_W   = 3 * DATA_W + 2 * REG_W + CTRL_W;

  logic [PL_W-1:0] in_pl;
  logic [PL_W-1:0] main_q, main_d;
  logic [PL_W-1:0] skid_q, skid_d;
  logic            main_v_q, main_v_d;
  logic            skid_v_q, skid_v_d;
  logic            rdy_q;
  logic [1:0]      occ_q;
  logic            xfer;
  logic            acc;

  assign in_pl = {in_imm, in_a, in_b, in_m1, in_m2,
                  in_alu_src, in_alu_fn, in_mem_write, in_mem_read, in_mem_to_reg};

  assign {out_imm, out_a, out_b, out_m1, out_m2,
          out_alu_src, out_alu_fn, out_mem_write, out_mem_read, out_mem_to_reg} = main_q;
  assign out_valid = main_v_q;
  assign in_ready  = rdy_q;
  assign occ       = occ_q;

  // Next-state for main/skid entries: drain skid into main, then accept into the free slot.
  always_comb begin
    main_d   = main_q;
    skid_d   = skid_q;
    main_v_d = main_v_q;
    skid_v_d = skid_v_q;
    xfer     = main_v_q & out_ready;
    acc      = in_valid & rdy_q;

    if (xfer) begin
      if (skid_v_q) begin
        main_d   = skid_q;
        skid_v_d = acc;
        if (acc) begin
          skid_d = in_pl;
        end
      end else begin
        main_v_d = acc;
        if (acc) begin
          main_d = in_pl;
        end else begin
          main_d = {main_q[PL_W-1:CTRL_W], {CTRL_W{1'b0}}};
        end
      end
    end else if (!main_v_q) begin
      if (acc) begin
        main_v_d = 1'b1;
        main_d   = in_pl;
      end
    end else if (!skid_v_q) begin
      if (acc) begin
        skid_v_d = 1'b1;
        skid_d   = in_pl;
      end
    end

    // Squash keeps the current data fields but never exposes live control bits.
    if (flush) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
      main_d   = {main_q[PL_W-1:CTRL_W], {CTRL_W{1'b0}}};
      skid_d   = skid_q;
    end
  end

  // State registers; in_ready and occ are flopped from the next-state values.
  always_ff @(posedge clk2) begin
    if (rst) begin
      main_q   <= '0;
      skid_q   <= '0;
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      rdy_q    <= 1'b1;
      occ_q    <= 2'd0;
    end else begin
      main_q   <= main_d;
      skid_q   <= skid_d;
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
      rdy_q    <= ~skid_v_d;
      occ_q    <= 2'(main_v_d) + 2'(skid_v_d);
    end
  end

endmodule
